// File: rtl/crc_stream_pkg.sv
// Shared FSM encodings and standard generator polynomials for the streaming CRC engine.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] CRC8_POLY   = 32'h0000_0007;
  localparam logic [31:0] CRC16_CCITT = 32'h0000_1021;
  localparam logic [31:0] CRC32_POLY  = 32'h04C1_1DB7;

  // Picks the common polynomial for a register width; anything unusual falls back to CRC-8.
  function automatic logic [31:0] std_poly(input int w);
    case (w)
      16:      return CRC16_CCITT;
      32:      return CRC32_POLY;
      default: return CRC8_POLY;
    endcase
  endfunction

endpackage

// File: rtl/crc_stream_step.sv
// Combinational CRC update: DATA_W serial LFSR shifts (data MSB first) unrolled into one step.
module crc_step #(
  parameter int              CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY  = '0,
  parameter int              DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] w_c;

  always_comb begin
    w_c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (w_c[CRC_W-1] ^ data[i]) w_c = (w_c << 1) ^ POLY;
      else                        w_c = w_c << 1;
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/crc_stream.sv
// Framed streaming CRC: one beat per clock, result registered one cycle after the last beat
// and held (input back-pressured) until the consumer takes it.
(* tamara_triplicate *)
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int          CRC_W       = 8,
  parameter logic [31:0] POLY        = std_poly(CRC_W),
  parameter logic [31:0] INIT        = 32'h0,
  parameter logic [31:0] XOR_OUT     = 32'h0,
  parameter int          DATA_W      = 8,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [CRC_W-1:0]  chk_crc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_match,
  (* tamara_error_sink *)
  output logic              error
);

  localparam logic [CRC_W-1:0] LP_POLY = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] LP_INIT = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] LP_XOR  = XOR_OUT[CRC_W-1:0];

  state_t           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] r_out_crc;
  logic             r_out_valid;
  logic             r_out_match;
  logic             r_err;
  logic             r_in_ready;

  logic [DATA_W-1:0] w_data;
  logic [CRC_W-1:0]  w_crc_in;
  logic [CRC_W-1:0]  w_crc_nxt;
  logic [CRC_W-1:0]  w_crc_ref;
  logic [CRC_W-1:0]  w_res;
  logic              w_acc;
  logic              w_take;
  logic              w_close;
  logic              w_proto_err;

  if (REFLECT_IN) begin : g_rin
    always_comb begin
      w_data = '0;
      for (int i = 0; i < DATA_W; i++) w_data[i] = in_data[DATA_W-1-i];
    end
  end else begin : g_nrin
    assign w_data = in_data;
  end

  // A first beat always restarts from INIT, whether the frame was idle or still open.
  assign w_acc       = in_valid & r_in_ready;
  assign w_take      = w_acc & ((r_state == ST_ACCUM) | in_first);
  assign w_close     = w_take & in_last;
  assign w_proto_err = w_acc & (((r_state == ST_IDLE) & ~in_first) |
                                ((r_state == ST_ACCUM) & in_first));
  assign w_crc_in    = ((r_state == ST_IDLE) | in_first) ? LP_INIT : r_crc;

  crc_step #(
    .CRC_W  (CRC_W),
    .POLY   (LP_POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_in  (w_crc_in),
    .data    (w_data),
    .crc_out (w_crc_nxt)
  );

  if (REFLECT_OUT) begin : g_rout
    always_comb begin
      w_crc_ref = '0;
      for (int i = 0; i < CRC_W; i++) w_crc_ref[i] = w_crc_nxt[CRC_W-1-i];
    end
  end else begin : g_nrout
    assign w_crc_ref = w_crc_nxt;
  end

  assign w_res = w_crc_ref ^ LP_XOR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_crc       <= LP_INIT;
      r_out_crc   <= '0;
      r_out_valid <= 1'b0;
      r_out_match <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      if (w_take)      r_crc <= w_crc_nxt;
      if (w_proto_err) r_err <= 1'b1;
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_close) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_crc   <= w_res;
            r_out_match <= (w_res == chk_crc);
            r_in_ready  <= 1'b0;
          end else if (w_take) begin
            r_state <= ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_crc   = r_out_crc;
  assign out_match = r_out_match;
  assign error     = r_err;

endmodule
